pe_array_ctrl: RTL and testbench
================================

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample and PE data width.
REQ-002 SHALL have parameter N_PE, default 8, samples per block, equal to the PE chain length (power of two, >=4).
REQ-003 SHALL have parameter LOAD_CYCLES, default 2, number of leading samples per block that assert load.
REQ-004 SHALL have parameter DRAIN_CYCLES, default N_PE, number of flush cycles after the last sample.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: block start request.
REQ-008 SHALL have port abort, input, 1 bit: cancel the current block.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-010 SHALL have port in_data, input, DATA_WIDTH bits: sample.
REQ-011 SHALL have port in_ready, output, 1 bit: sample accepted when in_valid && in_ready.
REQ-012 SHALL have port ready, output, 1 bit: idle, start accepted.
REQ-013 SHALL have port x_out, output, DATA_WIDTH bits: to PE0 xIn.
REQ-014 SHALL have port load_out, output, 1 bit: to PE0 loadIn.
REQ-015 SHALL have port sum_diff_sel_out, output, 1 bit: to PE0 sumDiffSelIn.
REQ-016 SHALL have port coef_addr, output, $clog2(N_PE) bits: coefficient ROM address.
REQ-017 SHALL have port z_capture, output, 1 bit: zOut of the last PE is valid this cycle.
REQ-018 SHALL have port done, output, 1 bit: one-cycle end-of-block pulse.
REQ-019 SHALL have port block_cnt, output, 16 bits: count of completed blocks.

Function
REQ-020 SHALL implement FSM states IDLE, FEED, DRAIN, DONE; all outputs registered.
REQ-021 IDLE: ready=1, in_ready=0; start=1 -> FEED next cycle, sample index idx=0.
REQ-022 FEED: in_ready=1; each accepted sample k drives, on the next cycle, x_out=in_data, coef_addr=k, sum_diff_sel_out=k[0], load_out=(k<LOAD_CYCLES).
REQ-023 FEED stall (in_valid=0): x_out and coef_addr hold, load_out=0, idx holds, and sum_diff_sel_out holds.
REQ-024 Acceptance of sample N_PE-1 -> DRAIN next cycle, drain counter=0.
REQ-025 DRAIN: in_ready=0, x_out=0, load_out=0, sum_diff_sel_out=0, and coef_addr increments mod N_PE each cycle; z_capture=1 for every DRAIN cycle.
REQ-026 After DRAIN_CYCLES cycles -> DONE; DONE lasts one cycle with done=1, block_cnt increments (wraps 0xFFFF->0), then -> IDLE.
REQ-027 start outside IDLE SHALL be ignored; start and abort together in IDLE -> stay IDLE.
REQ-028 abort in FEED/DRAIN -> IDLE next cycle, done not pulsed, block_cnt unchanged, and load_out/z_capture=0 from that cycle.
REQ-029 Total latency, no stalls: start at edge t -> done high in cycle t+1+N_PE+DRAIN_CYCLES+1.
REQ-030 Counters SHALL wrap exactly at N_PE-1 with no out-of-range coef_addr.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, x_out=0, coef_addr=0, load_out=0, sum_diff_sel_out=0, z_capture=0, done=0, in_ready=0, ready=1 (after reset), block_cnt=0.
REQ-032 Reset mid-block SHALL discard the block; the first start after rst deassertion SHALL behave as from power-up.

Verification
REQ-033 Start, samples 0..7 back-to-back -> load_out=1 on samples 0,1 only; sum_diff_sel_out=0,1,0,1..; z_capture 8 cycles; done once; block_cnt=1.
REQ-034 Same block with in_valid low two cycles after sample 3 -> x_out holds 3, load_out=0 during stall, done delayed exactly 2 cycles.
REQ-035 Abort during DRAIN cycle 3 -> IDLE next cycle, no done, and block_cnt unchanged.
REQ-036 rst asserted mid-FEED (asynchronous, between edges) -> outputs at reset values before next edge; new block completes normally.
REQ-037 start pulsed during FEED and DRAIN -> ignored; exactly one done per accepted start.
REQ-038 65536 back-to-back blocks (or forced counter) -> block_cnt wraps to 0.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences one block of N_PE samples into the head of a PE
// chain, then flushes the chain for DRAIN_CYCLES cycles while the tail output
// is captured, and finally pulses done.
//
// Handshake: a sample is transferred on a rising edge where in_valid && in_ready.
// in_valid may rise or fall in any cycle. in_ready is a registered output and
// opens one cycle after the controller enters FEED. It closes on the same edge
// that accepts sample N_PE-1.
// start is honoured only while ready=1 (IDLE). start together with abort is
// treated as no request.
//
// Every output is registered, so each output shows the decision made on the
// previous edge. As a result, for a start sampled at edge t with no stalls,
// done is high in cycle t+1+N_PE+DRAIN_CYCLES+1.
// state_dbg exposes the FSM state register for observation.
module pe_array_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int N_PE         = 8,
  parameter int LOAD_CYCLES  = 2,
  parameter int DRAIN_CYCLES = N_PE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      ready,
  output logic [DATA_WIDTH-1:0]     x_out,
  output logic                      load_out,
  output logic                      sum_diff_sel_out,
  output logic [$clog2(N_PE)-1:0]   coef_addr,
  output logic                      z_capture,
  output logic                      done,
  output logic [15:0]               block_cnt,
  output logic [1:0]                state_dbg
);

  localparam int AW = $clog2(N_PE);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [AW-1:0] idx;
  logic [CW-1:0] drain_cnt;
  logic          accept;
  logic          last_sample;
  logic          drain_end;

  assign accept      = in_valid && in_ready;
  assign last_sample = accept && (idx == AW'(N_PE - 1));
  assign drain_end   = (drain_cnt == CW'(DRAIN_CYCLES - 1));
  assign state_dbg   = state;

  // Next-state decision; abort wins over progress in FEED and DRAIN
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && !abort) state_nx = S_FEED;
      S_FEED:  if (abort) state_nx = S_IDLE;
               else if (last_sample) state_nx = S_DRAIN;
      S_DRAIN: if (abort) state_nx = S_IDLE;
               else if (drain_end) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, sample index and drain counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nx;
      // idx wraps naturally at N_PE-1 because N_PE is a power of two
      if (state == S_IDLE)
        idx <= '0;
      else if (state == S_FEED && accept)
        idx <= idx + AW'(1);
      if (state == S_DRAIN)
        drain_cnt <= drain_cnt + CW'(1);
      else
        drain_cnt <= '0;
    end
  end

  // Registered outputs toward the PE chain and the block status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready            <= 1'b1;
      in_ready         <= 1'b0;
      x_out            <= '0;
      coef_addr        <= '0;
      load_out         <= 1'b0;
      sum_diff_sel_out <= 1'b0;
      z_capture        <= 1'b0;
      done             <= 1'b0;
      block_cnt        <= 16'd0;
    end else begin
      ready     <= (state_nx == S_IDLE);
      in_ready  <= (state == S_FEED) && (state_nx == S_FEED);
      done      <= (state == S_DONE);
      z_capture <= (state == S_DRAIN) && !abort;
      load_out  <= 1'b0;
      if (state == S_DONE)
        block_cnt <= block_cnt + 16'd1;
      case (state)
        S_FEED: begin
          if (abort) begin
            x_out            <= '0;
            coef_addr        <= '0;
            sum_diff_sel_out <= 1'b0;
          end else if (accept) begin
            x_out            <= in_data;
            coef_addr        <= idx;
            sum_diff_sel_out <= idx[0];
            load_out         <= (32'(idx) < LOAD_CYCLES);
          end
        end
        S_DRAIN: begin
          x_out            <= '0;
          sum_diff_sel_out <= 1'b0;
          if (abort)
            coef_addr <= '0;
          else
            coef_addr <= coef_addr + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: random sample blocks with stalls, ignored start pulses,
// abort, mid-block reset and counter wrap, checked by a scoreboard.
module tb_pe_array_ctrl;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int LC = 2;
  localparam int DC = N;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start, abort, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, ready, load_out, sum_diff_sel_out, z_capture, done;
  logic [DW-1:0] x_out;
  logic [AW-1:0] coef_addr;
  logic [15:0]   block_cnt;
  logic [1:0]    state_dbg;

  pe_array_ctrl #(.DATA_WIDTH(DW), .N_PE(N), .LOAD_CYCLES(LC), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ready(ready), .x_out(x_out),
    .load_out(load_out), .sum_diff_sel_out(sum_diff_sel_out), .coef_addr(coef_addr),
    .z_capture(z_capture), .done(done), .block_cnt(block_cnt), .state_dbg(state_dbg)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int vectors = 0;
  int miscompares = 0;
  logic [DW+AW-1:0] exp_q[$];   // {data, sample index}
  logic [47:0]      blk_q[$];   // {expected done cycle, expected block_cnt}
  logic [15:0]      model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the queued expectations
  logic          pend_acc = 1'b0;
  logic          have_s = 1'b0;
  logic [DW-1:0] last_x;
  logic [AW-1:0] last_k;
  int            zj = 0;
  logic [DW+AW-1:0] se;
  logic [47:0]      be;

  always @(negedge clk) begin
    if (rst) begin
      pend_acc = 1'b0;
      have_s   = 1'b0;
      zj       = 0;
    end else begin
      if (pend_acc) begin
        if (exp_q.size() == 0) check("sample_unexpected", 32'd1, 32'd0);
        else begin
          se = exp_q.pop_front();
          check("x_out", 32'(x_out), 32'(se[DW+AW-1:AW]));
          check("coef_addr", 32'(coef_addr), 32'(se[AW-1:0]));
          check("sum_diff_sel", 32'(sum_diff_sel_out), 32'(se[AW-1:0]) % 2);
          check("load_out", 32'(load_out), 32'(int'(se[AW-1:0]) < LC));
          last_x = se[DW+AW-1:AW];
          last_k = se[AW-1:0];
          have_s = 1'b1;
        end
      end else begin
        check("load_no_sample", 32'(load_out), 32'd0);
        if (in_ready && have_s) begin
          check("stall_x_hold", 32'(x_out), 32'(last_x));
          check("stall_coef_hold", 32'(coef_addr), 32'(last_k));
          check("stall_sds_hold", 32'(sum_diff_sel_out), 32'(last_k) % 2);
        end
      end
      if (z_capture) begin
        check("drain_x", 32'(x_out), 32'd0);
        check("drain_load", 32'(load_out), 32'd0);
        check("drain_sds", 32'(sum_diff_sel_out), 32'd0);
        check("drain_coef", 32'(coef_addr), 32'((N - 1 + zj + 1) % N));
        zj++;
      end
      if (done) begin
        if (blk_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          be = blk_q.pop_front();
          check("done_cycle", cyc, be[47:16]);
          check("block_cnt", 32'(block_cnt), 32'(be[15:0]));
          check("z_count", zj, DC);
        end
      end
      pend_acc = in_valid && in_ready;
      if (start && ready && !abort) begin
        zj     = 0;
        have_s = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic wait_ready();
    bit ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      ok = ready;
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_x_out"}, 32'(x_out), 32'd0);
    check({tag, "_coef"}, 32'(coef_addr), 32'd0);
    check({tag, "_load"}, 32'(load_out), 32'd0);
    check({tag, "_sds"}, 32'(sum_diff_sel_out), 32'd0);
    check({tag, "_z"}, 32'(z_capture), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_block_cnt"}, 32'(block_cnt), 32'd0);
  endtask

  task automatic run_block(input int stall_at, input int stall_len, input bit noise,
                           input bit do_abort, input int rst_at);
    int            t0;
    logic [DW-1:0] d;
    bit            acc;
    wait_ready();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      d = DW'($urandom);
      in_valid = 1'b1;
      in_data  = d;
      exp_q.push_back({d, AW'(k)});
      acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      start = noise && (k == 4);
      if (k == rst_at) begin
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midfeed_rst");
        exp_q.delete();
        blk_q.delete();
        model_cnt = 16'd0;
        @(posedge clk); #3;
        rst = 1'b0;
        return;
      end
      if (k == stall_at) begin
        in_valid = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
        end
      end
    end
    in_valid = 1'b0;
    if (do_abort) begin
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_z", 32'(z_capture), 32'd0);
      check("abort_load", 32'(load_out), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      check("abort_block_cnt", 32'(block_cnt), 32'(model_cnt));
      return;
    end
    blk_q.push_back({32'(t0 + 2 + N + DC + stall_len), 16'((32'(model_cnt) + 1) % 65536)});
    model_cnt = 16'((32'(model_cnt) + 1) % 65536);
    if (noise) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // Main sequence
  initial begin
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    model_cnt = 16'd0;
    #1 rst = 1'b1;
    #1 check_reset_values("por");
    @(posedge clk); #3;
    rst = 1'b0;

    // start and abort together in IDLE must not leave IDLE
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("start_abort_in_ready", 32'(in_ready), 32'd0);

    run_block(-1, 0, 1'b0, 1'b0, -1);
    run_block(3, 2, 1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++)
      run_block(int'($urandom_range(0, N - 2)), int'($urandom_range(1, 3)), 1'b0, 1'b0, -1);
    run_block(-1, 0, 1'b1, 1'b0, -1);
    run_block(-1, 0, 1'b0, 1'b1, -1);
    run_block(-1, 0, 1'b0, 1'b0, 3);
    run_block(-1, 0, 1'b0, 1'b0, -1);

    // counter wrap: preload block_cnt to its maximum, then finish one block
    wait_ready();
    @(posedge clk); #1;
    force dut.block_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.block_cnt;
    @(negedge clk);
    check("force_hold", 32'(block_cnt), 32'h0000FFFF);
    model_cnt = 16'hFFFF;
    run_block(int'($urandom_range(0, N - 2)), 1, 1'b0, 1'b0, -1);

    wait_ready();
    repeat (5) @(negedge clk);
    check("sample_q_empty", exp_q.size(), 32'd0);
    check("block_q_empty", blk_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
